// File: rtl/label_mmu_pkg.sv
// Shared definitions for the label MMU: label type codes, fault causes,
// FSM state encoding and the label-table entry layout.
package label_mmu_pkg;

  // Label type codes. UNDEFINED is a wildcard on the request side only. It is
  // deliberately non-zero so that a request with type 0 is an ordinary typed
  // request.
  localparam logic [5:0] LBTYPE_NONE      = 6'h00;
  localparam logic [5:0] LBTYPE_CODE      = 6'h01;
  localparam logic [5:0] LBTYPE_DATA      = 6'h02;
  localparam logic [5:0] LBTYPE_STACK     = 6'h03;
  localparam logic [5:0] LBTYPE_UNDEFINED = 6'h3F;

  typedef enum logic [1:0] {
    MMU_CAUSE_OK      = 2'd0,
    MMU_CAUSE_NOLABEL = 2'd1,
    MMU_CAUSE_TYPE    = 2'd2,
    MMU_CAUSE_BOUNDS  = 2'd3
  } mmu_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } mmu_state_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  typ;
    logic [15:0] base;
    logic [15:0] count;
  } lbt_entry_t;

endpackage

// File: rtl/label_mmu_table_ram.sv
// label_table_ram: LBT_DEPTH-entry label table register file.
//   clk, reset_n   clock / asynchronous active-low reset (clears every entry)
//   i_we, i_wr_idx write strobe and entry index (caller filters out-of-range ids)
//   i_wr_typ/base/count  entry fields; a write also sets the entry valid bit
//   i_rd_idx       asynchronous read index
//   o_rd_entry     entry at i_rd_idx
module label_table_ram
  import label_mmu_pkg::*;
#(
  parameter int unsigned LBT_DEPTH = 16,
  parameter int unsigned LBT_AW    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [LBT_AW-1:0] i_wr_idx,
  input  logic [5:0]        i_wr_typ,
  input  logic [15:0]       i_wr_base,
  input  logic [15:0]       i_wr_count,
  input  logic [LBT_AW-1:0] i_rd_idx,
  output lbt_entry_t        o_rd_entry
);

  lbt_entry_t r_mem [LBT_DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LBT_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wr_idx] <= '{valid: 1'b1, typ: i_wr_typ, base: i_wr_base, count: i_wr_count};
    end
  end

  assign o_rd_entry = r_mem[i_rd_idx];

endmodule

// File: rtl/label_mmu.sv
// label_mmu: responder for label-table translation requests.
//   Label-table write port: lbt_we, lbt_lbidw, lbt_typw, lbt_basew, lbt_countw
//   Request  (valid/ready): req_valid, req_ready, mmu_reqType, mmu_lbid, mmu_ofs
//   Response (valid/ready): resp_valid, resp_ready, mmu_addr, mmu_invalid, mmu_cause
//   Optional (MMU_FAULT_CNT_EN): fault_cnt (saturating fault count), fault_clr
// FSM IDLE -> CHECK -> RESP -> IDLE; fault priority NOLABEL > TYPE > BOUNDS.
module label_mmu
  import label_mmu_pkg::*;
#(
  parameter int unsigned LBT_DEPTH = 16,
  parameter int unsigned LBT_AW    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lbt_we,
  input  logic [11:0] lbt_lbidw,
  input  logic [5:0]  lbt_typw,
  input  logic [15:0] lbt_basew,
  input  logic [15:0] lbt_countw,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  mmu_reqType,
  input  logic [11:0] mmu_lbid,
  input  logic [15:0] mmu_ofs,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] mmu_addr,
  output logic        mmu_invalid,
  output logic [1:0]  mmu_cause
`ifdef MMU_FAULT_CNT_EN
  ,
  output logic [15:0] fault_cnt,
  input  logic        fault_clr
`endif
);

  localparam logic [11:0] LP_DEPTH = 12'(LBT_DEPTH);

  mmu_state_t r_state, w_state_nxt;

  logic [5:0]  r_reqType;
  logic [11:0] r_lbid;
  logic [15:0] r_ofs;
  logic [15:0] r_addr;
  logic        r_invalid;
  mmu_cause_t  r_cause;

  logic        w_wr_en;
  lbt_entry_t  w_rd_entry;
  lbt_entry_t  w_entry;
  logic        w_lbid_ok;
  mmu_cause_t  w_cause;
  logic        w_invalid;
  logic [15:0] w_addr;

  assign w_wr_en = lbt_we && (lbt_lbidw < LP_DEPTH);

  label_table_ram #(
    .LBT_DEPTH (LBT_DEPTH),
    .LBT_AW    (LBT_AW)
  ) u_table (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we       (w_wr_en),
    .i_wr_idx   (lbt_lbidw[LBT_AW-1:0]),
    .i_wr_typ   (lbt_typw),
    .i_wr_base  (lbt_basew),
    .i_wr_count (lbt_countw),
    .i_rd_idx   (r_lbid[LBT_AW-1:0]),
    .o_rd_entry (w_rd_entry)
  );

  // A same-cycle write to the entry being evaluated bypasses the table so
  // the check sees the new contents.
  always_comb begin
    w_entry = w_rd_entry;
    if (w_wr_en && (lbt_lbidw == r_lbid)) begin
      w_entry = '{valid: 1'b1, typ: lbt_typw, base: lbt_basew, count: lbt_countw};
    end
  end

  assign w_lbid_ok = (r_lbid < LP_DEPTH);

  always_comb begin
    w_cause = MMU_CAUSE_OK;
    if (!w_lbid_ok || !w_entry.valid) begin
      w_cause = MMU_CAUSE_NOLABEL;
    end else if ((r_reqType != LBTYPE_UNDEFINED) && (r_reqType != w_entry.typ)) begin
      w_cause = MMU_CAUSE_TYPE;
    end else if (r_ofs >= w_entry.count) begin
      w_cause = MMU_CAUSE_BOUNDS;
    end
  end

  assign w_invalid = (w_cause != MMU_CAUSE_OK);
  assign w_addr    = w_invalid ? '0 : (w_entry.base + r_ofs);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_reqType <= '0;
      r_lbid    <= '0;
      r_ofs     <= '0;
      r_addr    <= '0;
      r_invalid <= 1'b0;
      r_cause   <= MMU_CAUSE_OK;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && req_valid) begin
        r_reqType <= mmu_reqType;
        r_lbid    <= mmu_lbid;
        r_ofs     <= mmu_ofs;
      end
      if (r_state == ST_CHECK) begin
        r_addr    <= w_addr;
        r_invalid <= w_invalid;
        r_cause   <= w_cause;
      end
    end
  end

  assign mmu_addr    = r_addr;
  assign mmu_invalid = r_invalid;
  assign mmu_cause   = r_cause;

`ifdef MMU_FAULT_CNT_EN
  logic [15:0] r_fault_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fault_cnt <= '0;
    end else if (fault_clr) begin
      r_fault_cnt <= '0;
    end else if ((r_state == ST_CHECK) && w_invalid && (r_fault_cnt != '1)) begin
      r_fault_cnt <= r_fault_cnt + 16'd1;
    end
  end

  assign fault_cnt = r_fault_cnt;
`endif

endmodule
